// File: rtl/loop_filter.sv
// loop_filter: proportional-integral loop filter for a digital PLL.
//
// A phase-error sample strobed by pd_valid_i walks a three-state pipeline:
// IDLE captures the error, INTEG accumulates it into a saturating integrator,
// and SUM forms CENTER + (err >>> KP_SHIFT) + (integ >>> KI_SHIFT). The result
// is clamped to the unsigned output range and registered as the DCO control word.
//
// Optional feature: define LOOP_FILTER_LOCK_DETECT_EN to build the lock detector.
// Without it, lock_o is tied low and no lock counter exists.
//
// Ports:
//   fpga_clk_i        single clock, rising edge
//   reset_i           asynchronous active-low reset
//   pd_clock_cycles_i signed phase error (WIDTH bits)
//   pd_valid_i        one-cycle strobe for a new phase-error sample
//   hold_i            freezes the integrator during INTEG
//   ctrl_word_o       registered unsigned DCO tuning word (OUT_WIDTH bits)
//   ctrl_valid_o      one-cycle strobe on each ctrl_word_o update
//   sat_o             last update clamped the integrator or the output
//   overrun_o         one-cycle pulse when a sample is dropped (FSM busy)
//   lock_o            loop-locked indicator
module loop_filter #(
  parameter int                  WIDTH      = 20,
  parameter int                  OUT_WIDTH  = 24,
  parameter int                  INT_WIDTH  = 32,
  parameter int                  KP_SHIFT   = 2,
  parameter int                  KI_SHIFT   = 4,
  parameter logic [OUT_WIDTH-1:0] CENTER    = 24'h800000,
  parameter int                  LOCK_TOL   = 4,
  parameter int                  LOCK_COUNT = 16
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  input  logic [WIDTH-1:0]     pd_clock_cycles_i,
  input  logic                 pd_valid_i,
  input  logic                 hold_i,
  output logic [OUT_WIDTH-1:0] ctrl_word_o,
  output logic                 ctrl_valid_o,
  output logic                 sat_o,
  output logic                 overrun_o,
  output logic                 lock_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INTEG = 2'd1;
  localparam logic [1:0] ST_SUM   = 2'd2;

  // Output sum width: integrator plus headroom for the centre and P terms.
  localparam int SW = INT_WIDTH + 2;

  logic [1:0]                  state_q;
  logic [WIDTH-1:0]            err_q;
  logic signed [INT_WIDTH-1:0] integ_q;
  logic                        integ_sat_q;
  logic [OUT_WIDTH-1:0]        ctrl_word_q;
  logic                        ctrl_valid_q;
  logic                        sat_q;
  logic                        overrun_q;

  // Integrator update with symmetric saturation.
  logic signed [INT_WIDTH-1:0] err_ext;
  logic signed [INT_WIDTH:0]   integ_sum;
  logic signed [INT_WIDTH-1:0] integ_next;
  logic                        integ_clamp;

  assign err_ext   = {{(INT_WIDTH-WIDTH){err_q[WIDTH-1]}}, err_q};
  assign integ_sum = {integ_q[INT_WIDTH-1], integ_q} + {err_ext[INT_WIDTH-1], err_ext};

  always_comb begin
    integ_clamp = 1'b0;
    integ_next  = integ_sum[INT_WIDTH-1:0];
    // The two top bits disagree only on overflow; the top bit gives the true sign.
    if (integ_sum[INT_WIDTH] != integ_sum[INT_WIDTH-1]) begin
      integ_clamp = 1'b1;
      integ_next  = integ_sum[INT_WIDTH] ? {1'b1, {(INT_WIDTH-1){1'b0}}}
                                         : {1'b0, {(INT_WIDTH-1){1'b1}}};
    end
  end

  // Output sum: CENTER + P + I, clamped into [0, 2^OUT_WIDTH-1].
  logic signed [SW-1:0]  err_wide;
  logic signed [SW-1:0]  integ_wide;
  logic signed [SW-1:0]  center_wide;
  logic signed [SW-1:0]  out_sum;
  logic [OUT_WIDTH-1:0]  out_word;
  logic                  out_clamp;

  assign err_wide    = {{(SW-WIDTH){err_q[WIDTH-1]}}, err_q};
  assign integ_wide  = {{2{integ_q[INT_WIDTH-1]}}, integ_q};
  assign center_wide = {{(SW-OUT_WIDTH){1'b0}}, CENTER};
  assign out_sum     = center_wide + (err_wide >>> KP_SHIFT) + (integ_wide >>> KI_SHIFT);

  always_comb begin
    out_clamp = 1'b0;
    out_word  = out_sum[OUT_WIDTH-1:0];
    if (out_sum[SW-1]) begin
      out_clamp = 1'b1;
      out_word  = '0;
    end else if (|out_sum[SW-2:OUT_WIDTH]) begin
      out_clamp = 1'b1;
      out_word  = '1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      err_q        <= '0;
      integ_q      <= '0;
      integ_sat_q  <= 1'b0;
      ctrl_word_q  <= CENTER;
      ctrl_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      ctrl_valid_q <= 1'b0;
      // A strobe arriving while busy is dropped and flagged on the next cycle.
      overrun_q    <= pd_valid_i && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (pd_valid_i) begin
            err_q   <= pd_clock_cycles_i;
            state_q <= ST_INTEG;
          end
        end
        ST_INTEG: begin
          if (hold_i) begin
            integ_sat_q <= 1'b0;
          end else begin
            integ_q     <= integ_next;
            integ_sat_q <= integ_clamp;
          end
          state_q <= ST_SUM;
        end
        ST_SUM: begin
          ctrl_word_q  <= out_word;
          ctrl_valid_q <= 1'b1;
          sat_q        <= integ_sat_q | out_clamp;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_word_o  = ctrl_word_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign sat_o        = sat_q;
  assign overrun_o    = overrun_q;

`ifdef LOOP_FILTER_LOCK_DETECT_EN
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]    LOCK_MAX = CW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] TOL      = WIDTH'(LOCK_TOL);

  logic [CW-1:0]    lock_cnt_q;
  logic [CW-1:0]    lock_cnt_d;
  logic             lock_q;
  logic [WIDTH-1:0] err_abs;

  // Unsigned magnitude; the most negative input maps to 2^(WIDTH-1) exactly.
  assign err_abs = err_q[WIDTH-1] ? (~err_q + WIDTH'(1)) : err_q;

  always_comb begin
    lock_cnt_d = '0;
    if (err_abs <= TOL) begin
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + CW'(1);
    end
  end

  // Updated at the SUM edge so lock_o changes in the ctrl_valid_o cycle.
  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else if (state_q == ST_SUM) begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= (lock_cnt_d == LOCK_MAX);
    end
  end

  assign lock_o = lock_q;
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_loop_filter.sv
// Directed self-checking bench for loop_filter at default parameters.
module tb_loop_filter;

  logic        clk;
  logic        reset;
  logic [19:0] pd;
  logic        pd_valid;
  logic        hold;
  logic [23:0] word;
  logic        cvalid;
  logic        sat;
  logic        overrun;
  logic        lock;

  int vectors     = 0;
  int miscompares = 0;

`ifdef LOOP_FILTER_LOCK_DETECT_EN
  localparam logic LOCK_EXP = 1'b1;
`else
  localparam logic LOCK_EXP = 1'b0;
`endif

  loop_filter dut (
    .fpga_clk_i       (clk),
    .reset_i          (reset),
    .pd_clock_cycles_i(pd),
    .pd_valid_i       (pd_valid),
    .hold_i           (hold),
    .ctrl_word_o      (word),
    .ctrl_valid_o     (cvalid),
    .sat_o            (sat),
    .overrun_o        (overrun),
    .lock_o           (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Assert reset between edges, check the cleared outputs, release before an edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_word", {8'h0, word}, 32'h800000);
    chk("rst_valid", {31'h0, cvalid}, 0);
    chk("rst_sat", {31'h0, sat}, 0);
    chk("rst_overrun", {31'h0, overrun}, 0);
    chk("rst_lock", {31'h0, lock}, 0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Strobe one sample and check ctrl_valid_o rises only at n+3; returns in cycle n+3.
  task automatic send(input logic [19:0] e, input logic h);
    pd       = e;
    pd_valid = 1'b1;
    hold     = h;
    tick();
    pd_valid = 1'b0;
    pd       = '0;
    chk("lat_n1", {31'h0, cvalid}, 0);
    tick();
    hold = 1'b0;
    chk("lat_n2", {31'h0, cvalid}, 0);
    tick();
    chk("lat_n3", {31'h0, cvalid}, 1);
  endtask

  initial begin
    reset    = 1'b1;
    pd       = '0;
    pd_valid = 1'b0;
    hold     = 1'b0;
    #2;
    do_reset();

    // +64 then -64: P and I terms both visible.
    send(20'd64, 1'b0);
    chk("pos64_word", {8'h0, word}, 32'h800014);
    chk("pos64_sat", {31'h0, sat}, 0);
    tick();
    chk("hold_valid_low", {31'h0, cvalid}, 0);
    chk("hold_word", {8'h0, word}, 32'h800014);
    send(20'hFFFC0, 1'b0);
    chk("neg64_word", {8'h0, word}, 32'h7FFFF0);

    // hold_i freezes the integrator; a zero sample afterwards proves integ stayed 0.
    do_reset();
    send(20'd64, 1'b1);
    chk("hold64_word", {8'h0, word}, 32'h800010);
    send(20'd0, 1'b0);
    chk("hold_integ0", {8'h0, word}, 32'h800000);

    // Back-to-back strobes: second is dropped, overrun pulses once.
    do_reset();
    pd       = 20'd64;
    pd_valid = 1'b1;
    tick();
    chk("ovr_n1", {31'h0, overrun}, 0);
    pd = 20'd1000;
    tick();
    pd_valid = 1'b0;
    chk("ovr_n2", {31'h0, overrun}, 1);
    chk("ovr_valid_n2", {31'h0, cvalid}, 0);
    tick();
    chk("ovr_valid_n3", {31'h0, cvalid}, 1);
    chk("ovr_n3", {31'h0, overrun}, 0);
    chk("ovr_word", {8'h0, word}, 32'h800014);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ovr_no_2nd_valid", {31'h0, cvalid}, 0);
      chk("ovr_single", {31'h0, overrun}, 0);
    end

    // Reset in INTEG aborts the sample and clears the word asynchronously.
    do_reset();
    send(20'd64, 1'b0);
    chk("abort_pre_word", {8'h0, word}, 32'h800014);
    pd       = 20'd64;
    pd_valid = 1'b1;
    tick();
    pd_valid = 1'b0;
    #2;
    reset = 1'b0;
    #2;
    chk("abort_async_word", {8'h0, word}, 32'h800000);
    chk("abort_async_valid", {31'h0, cvalid}, 0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_valid", {31'h0, cvalid}, 0);
    end
    send(20'hFFFC0, 1'b0);
    chk("abort_next_word", {8'h0, word}, 32'h7FFFEC);

    // Large positive error ramps the output into the upper clamp at sample 253.
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      send(20'h7FFFF, 1'b0);
      if (k == 1) begin
        chk("ramp1_word", {8'h0, word}, 32'h827FFE);
        chk("ramp1_sat", {31'h0, sat}, 0);
      end
      if (k == 252) begin
        chk("ramp252_word", {8'h0, word}, 32'hFFFFEF);
        chk("ramp252_sat", {31'h0, sat}, 0);
      end
      if (k == 253) begin
        chk("ramp253_word", {8'h0, word}, 32'hFFFFFF);
        chk("ramp253_sat", {31'h0, sat}, 1);
      end
      if (k == 300) begin
        chk("ramp300_word", {8'h0, word}, 32'hFFFFFF);
        chk("ramp300_sat", {31'h0, sat}, 1);
      end
    end

    // Lock detection: 16 in-tolerance samples, then one out of tolerance.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      send(20'd3, 1'b0);
      if (k == 15) chk("lock15", {31'h0, lock}, 0);
      if (k == 16) chk("lock16", {31'h0, lock}, {31'h0, LOCK_EXP});
    end
    send(20'd10, 1'b0);
    chk("lock_lost", {31'h0, lock}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loop_filter.md
LOOP_FILTER -- requirements
Module: loop_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 20: width of the signed phase-error input.
REQ-002 SHALL have parameter OUT_WIDTH, default 24: width of the unsigned DCO control word.
REQ-003 SHALL have parameter INT_WIDTH, default 32: signed integrator width.
REQ-004 SHALL have parameter KP_SHIFT, default 2: proportional gain, err >>> KP_SHIFT.
REQ-005 SHALL have parameter KI_SHIFT, default 4: integral gain, integ >>> KI_SHIFT.
REQ-006 SHALL have parameter CENTER, default 24'h800000: control word at zero error.
REQ-007 SHALL have parameters LOCK_TOL, default 4, and LOCK_COUNT, default 16: lock tolerance in cycles and required consecutive in-tolerance samples.
REQ-008 SHALL have port fpga_clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port pd_clock_cycles_i, input, WIDTH bits: signed phase error from the phase detector.
REQ-011 SHALL have port pd_valid_i, input, 1 bit: one-cycle strobe marking a new pd_clock_cycles_i sample.
REQ-012 SHALL have port hold_i, input, 1 bit: freezes the integrator.
REQ-013 SHALL have port ctrl_word_o, output, OUT_WIDTH bits: registered DCO tuning word.
REQ-014 SHALL have port ctrl_valid_o, output, 1 bit: one-cycle strobe on each ctrl_word_o update.
REQ-015 SHALL have port sat_o, output, 1 bit: last update clamped the integrator or the output.
REQ-016 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a sample is dropped.
REQ-017 SHALL have port lock_o, output, 1 bit: loop-locked indicator.

Function
REQ-018 SHALL implement the FSM IDLE -> INTEG -> SUM -> IDLE; in IDLE, pd_valid_i=1 captures pd_clock_cycles_i into err and moves to INTEG; INTEG and SUM each last exactly one cycle.
REQ-019 In INTEG, SHALL sign-extend err to INT_WIDTH and set integ = integ + err, clamped to [-2^(INT_WIDTH-1), 2^(INT_WIDTH-1)-1]; when hold_i=1 in INTEG, integ SHALL remain unchanged.
REQ-020 In SUM, SHALL compute CENTER + (err >>> KP_SHIFT) + (integ >>> KI_SHIFT) at INT_WIDTH+2 signed bits (arithmetic shifts, round toward minus infinity), clamp to [0, 2^OUT_WIDTH-1], and register the result into ctrl_word_o.
REQ-021 Latency: pd_valid_i high in cycle n SHALL give ctrl_valid_o high in cycle n+3 only, with the new ctrl_word_o valid from cycle n+3.
REQ-022 sat_o SHALL update together with ctrl_word_o: 1 if either clamp in REQ-019 or REQ-020 engaged for that sample, else 0.
REQ-023 pd_valid_i=1 while the FSM is in INTEG or SUM SHALL be ignored, with overrun_o high for the following single cycle; the state and integrator SHALL be unaffected.
REQ-024 ctrl_word_o SHALL hold its value between updates.

Reset
REQ-025 reset_i=0 SHALL immediately force: FSM to IDLE, integ=0, err=0, ctrl_word_o=CENTER, ctrl_valid_o=0, sat_o=0, overrun_o=0, lock_o=0, lock counter=0.
REQ-026 Reset during INTEG or SUM SHALL abort the sample with no ctrl_valid_o; the first pd_valid_i after release SHALL be processed normally.

Configuration
REQ-027 With macro LOOP_FILTER_LOCK_DETECT_EN defined, each processed sample SHALL increment a lock counter (saturating at LOCK_COUNT) if |err| <= LOCK_TOL, else clear it; lock_o SHALL equal (counter == LOCK_COUNT) and update in the ctrl_valid_o cycle.
REQ-028 Without LOOP_FILTER_LOCK_DETECT_EN, lock_o SHALL be tied 0 and no lock counter logic SHALL exist.

Verification (default parameters)
REQ-029 Reset: assert reset_i=0 -> ctrl_word_o=0x800000, ctrl_valid_o=0, sat_o=0.
REQ-030 After reset, sample +64 -> ctrl_valid_o at n+3, ctrl_word_o=0x800014; then sample -64 -> ctrl_word_o=0x7FFFF0.
REQ-031 After reset, sample +64 with hold_i=1 -> ctrl_word_o=0x800010, integ stays 0.
REQ-032 300 samples of +524287 -> ctrl_word_o=0xFFFFFF and sat_o=1 from about sample 253 onward.
REQ-033 pd_valid_i high in two consecutive cycles -> one ctrl_valid_o only, overrun_o pulses once.
REQ-034 With the macro defined, 16 samples of +3 -> lock_o=1 at the 16th ctrl_valid_o; then one sample of +10 -> lock_o=0.
